// File: rtl/mem_access_unit.sv
// mem_access_unit: a request queue in front of a single-port memory.
// Requests (load/store) are accepted into a FIFO of DEPTH entries. A small
// FSM pops one request at a time, issues a one-cycle memory strobe, and then
// presents one response that is held until the consumer accepts it.
//
// Optional build macro: MAU_ALIGN_CHECK_EN
//   defined   -> requests with an odd byte address skip the memory access and
//                complete straight away with RespErr=1, RespData=0.
//   undefined -> RespErr is tied to 0 and every address is issued unmodified.
//
// Handshakes: a transfer happens on a rising Clock edge where valid and ready
// are both 1. ReqReady depends only on the registered queue count, so it never
// depends on ReqValid. RespValid is high only in RESP, and RespData/RespWrite/
// RespErr do not change while RespValid=1 and RespReady=0.
module mem_access_unit #(
    parameter int DEPTH = 2
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [15:0] ReqAddr,
    input  logic [15:0] ReqWData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [15:0] RespData,
    output logic        RespWrite,
    output logic        RespErr,
    output logic [15:0] MemAddr,
    output logic [15:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [15:0] MemReadData,
    output logic        Busy,
    output logic [1:0]  dbg_state
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_W = 2'd1,
        ISSUE_R = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Request queue storage and bookkeeping
    logic [15:0]   q_addr  [DEPTH];
    logic [15:0]   q_wdata [DEPTH];
    logic          q_write [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          q_empty;
    logic [15:0]   head_addr;
    logic [15:0]   head_wdata;
    logic          head_write;
    logic          head_misaligned;

    // Request currently being issued to memory
    logic [15:0]   cur_addr;
    logic [15:0]   cur_wdata;

    // Registered response fields
    logic [15:0]   resp_data;
    logic          resp_write;

    assign q_empty    = (count == '0);
    assign ReqReady   = (count != FULL_COUNT);
    assign push       = ReqValid && ReqReady;
    assign pop        = (state == IDLE) && !q_empty;

    assign head_addr  = q_addr[rd_ptr];
    assign head_wdata = q_wdata[rd_ptr];
    assign head_write = q_write[rd_ptr];

`ifdef MAU_ALIGN_CHECK_EN
    assign head_misaligned = head_addr[0];
`else
    assign head_misaligned = 1'b0;
`endif

    // Queue payload: written at the tail on every accepted request
    always_ff @(posedge Clock) begin
        if (push) begin
            q_addr[wr_ptr]  <= ReqAddr;
            q_wdata[wr_ptr] <= ReqWData;
            q_write[wr_ptr] <= ReqWrite;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (DEPTH == 1) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: one request per IDLE -> ISSUE -> RESP round trip
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pop) begin
                    if (head_misaligned) begin
                        state_nxt = RESP;
                    end else if (head_write) begin
                        state_nxt = ISSUE_W;
                    end else begin
                        state_nxt = ISSUE_R;
                    end
                end
            end
            ISSUE_W: state_nxt = RESP;
            ISSUE_R: state_nxt = RESP;
            RESP: begin
                if (RespReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the popped request so the memory strobe sees stable address/data
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cur_addr  <= '0;
            cur_wdata <= '0;
        end else if (pop) begin
            cur_addr  <= head_addr;
            cur_wdata <= head_write ? head_wdata : 16'h0000;
        end
    end

    // Memory strobes decoded from state, so reset drops them without waiting for an edge
    always_comb begin
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        MemAddr      = 16'h0000;
        MemWriteData = 16'h0000;
        unique case (state)
            ISSUE_W: begin
                MemWrite     = 1'b1;
                MemAddr      = cur_addr;
                MemWriteData = cur_wdata;
            end
            ISSUE_R: begin
                MemRead = 1'b1;
                MemAddr = cur_addr;
            end
            default: begin
                MemWrite = 1'b0;
            end
        endcase
    end

`ifdef MAU_ALIGN_CHECK_EN
    logic resp_err;

    // Response capture: loads take MemReadData, stores report 0, odd addresses report an error
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            resp_data  <= '0;
            resp_write <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop && head_misaligned) begin
                        resp_data  <= 16'h0000;
                        resp_write <= head_write;
                        resp_err   <= 1'b1;
                    end
                end
                ISSUE_W: begin
                    resp_data  <= 16'h0000;
                    resp_write <= 1'b1;
                    resp_err   <= 1'b0;
                end
                ISSUE_R: begin
                    resp_data  <= MemReadData;
                    resp_write <= 1'b0;
                    resp_err   <= 1'b0;
                end
                default: begin
                    resp_data <= resp_data;
                end
            endcase
        end
    end

    assign RespErr = resp_err;
`else
    // Response capture: loads take MemReadData, stores report 0
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            resp_data  <= '0;
            resp_write <= 1'b0;
        end else begin
            unique case (state)
                ISSUE_W: begin
                    resp_data  <= 16'h0000;
                    resp_write <= 1'b1;
                end
                ISSUE_R: begin
                    resp_data  <= MemReadData;
                    resp_write <= 1'b0;
                end
                default: begin
                    resp_data <= resp_data;
                end
            endcase
        end
    end

    assign RespErr = 1'b0;
`endif

    assign RespValid = (state == RESP);
    assign RespData  = resp_data;
    assign RespWrite = resp_write;
    assign Busy      = !q_empty || (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios against a request-level model.
// The model decides each response at acceptance time from a shadow memory
// (in-order, one access at a time), and a single monitor process compares the
// memory strobes and responses against it on every cycle.
module tb_mem_access_unit;

`ifdef MAU_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [15:0] ReqAddr;
    logic [15:0] ReqWData;
    logic        RespValid;
    logic        RespReady;
    logic [15:0] RespData;
    logic        RespWrite;
    logic        RespErr;
    logic [15:0] MemAddr;
    logic [15:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] MemReadData;
    logic        Busy;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    // Environment memory and the model's view of it
    logic [15:0] mem       [0:255] = '{default: 16'h0000};
    logic [15:0] model_mem [0:255] = '{default: 16'h0000};
    logic        pre_we   = 1'b0;
    logic [7:0]  pre_addr = 8'h00;
    logic [15:0] pre_data = 16'h0000;

    // Scoreboard: expected responses {err, write, data} and expected strobes {write, addr, wdata}
    logic [17:0] exp_q[$];
    logic [32:0] issue_q[$];
    logic [17:0] got_q[$];
    logic [31:0] wr_log[$];
    logic [15:0] rd_log[$];
    int          resp_cyc_q[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          resp_cnt = 0;
    int          disc_cnt = 0;
    logic        prev_clk = 1'b0;

    assign MemReadData = mem[MemAddr[7:0]];

    mem_access_unit #(.DEPTH(2)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqWrite     (ReqWrite),
        .ReqAddr      (ReqAddr),
        .ReqWData     (ReqWData),
        .RespValid    (RespValid),
        .RespReady    (RespReady),
        .RespData     (RespData),
        .RespWrite    (RespWrite),
        .RespErr      (RespErr),
        .MemAddr      (MemAddr),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData),
        .Busy         (Busy),
        .dbg_state    (dbg_state)
    );

    // Clock
    initial forever #5 Clock = ~Clock;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor + model: acceptance, memory, strobe and response checks in one process
    always @(posedge Clock or negedge Clock or negedge Reset_n) begin
        logic        is_pos;
        logic        is_neg;
        logic [17:0] r;
        logic [32:0] op;
        is_pos   = Clock && !prev_clk;
        is_neg   = !Clock && prev_clk;
        prev_clk = Clock;

        if (is_pos) begin
            cyc++;
            if (MemWrite) mem[MemAddr[7:0]] <= MemWriteData;
            if (pre_we) begin
                mem[pre_addr]       <= pre_data;
                model_mem[pre_addr]  = pre_data;
            end
        end

        if (!Reset_n) begin
            disc_cnt += exp_q.size();
            exp_q.delete();
            issue_q.delete();
            model_mem = mem;
            if (is_neg) begin
                check("reset_strobes", {MemWrite, MemRead, MemAddr, MemWriteData}, 0);
                check("reset_resp", {RespValid, RespErr, RespWrite, RespData}, 0);
                check("reset_busy_ready", {Busy, ReqReady}, 2'b01);
            end
        end else if (is_pos) begin
            if (ReqValid && ReqReady) begin
                acc_cnt++;
                r = {1'b0, ReqWrite, 16'h0000};
                if (ALIGN_CHK && ReqAddr[0]) begin
                    r[17] = 1'b1;
                end else if (ReqWrite) begin
                    model_mem[ReqAddr[7:0]] = ReqWData;
                    issue_q.push_back({1'b1, ReqAddr, ReqWData});
                end else begin
                    r[15:0] = model_mem[ReqAddr[7:0]];
                    issue_q.push_back({1'b0, ReqAddr, 16'h0000});
                end
                exp_q.push_back(r);
            end
            if (RespValid && RespReady) begin
                if (exp_q.size() == 0) note_fail("resp_unexpected_handshake");
                else void'(exp_q.pop_front());
                got_q.push_back({RespErr, RespWrite, RespData});
                resp_cyc_q.push_back(cyc);
                resp_cnt++;
            end
        end else if (is_neg) begin
            check("mem_exclusive", MemWrite && MemRead, 1'b0);
            if (MemWrite || MemRead) begin
                if (issue_q.size() == 0) begin
                    note_fail("strobe_unexpected");
                end else begin
                    op = issue_q.pop_front();
                    check("strobe_kind", {MemWrite, MemRead}, {op[32], !op[32]});
                    check("strobe_addr", MemAddr, op[31:16]);
                    if (MemWrite) check("strobe_wdata", MemWriteData, op[15:0]);
                end
                if (MemWrite) wr_log.push_back({MemAddr, MemWriteData});
                else rd_log.push_back(MemAddr);
            end else begin
                check("mem_bus_idle", {MemAddr, MemWriteData}, 0);
            end
            if (RespValid) begin
                if (exp_q.size() == 0) note_fail("resp_unexpected");
                else check("resp_fields", {RespErr, RespWrite, RespData}, exp_q[0]);
            end
            check("busy", Busy, exp_q.size() != 0);
        end
    end

    // Drivers
    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
        int n;
        n = 0;
        ReqValid = 1'b1;
        ReqWrite = w;
        ReqAddr  = a;
        ReqWData = d;
        @(negedge Clock);
        while (!ReqReady && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (!ReqReady) note_fail("send_timeout");
        @(posedge Clock);
        #1;
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        ReqAddr  = 16'h0000;
        ReqWData = 16'h0000;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge Clock);
        while (Busy && n < 300) begin
            @(negedge Clock);
            n++;
        end
        if (Busy) note_fail("idle_timeout");
        @(posedge Clock);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge Clock);
        #1;
        pre_we = 1'b0;
    endtask

    // Directed scenarios
    initial begin
        int          gb;
        int          wb;
        int          rb;
        int          cb;
        int          c0;
        int          a0;
        logic [23:0] pat;

        Reset_n   = 1'b1;
        ReqValid  = 1'b0;
        ReqWrite  = 1'b0;
        ReqAddr   = 16'h0000;
        ReqWData  = 16'h0000;
        RespReady = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        check("rst_ready", ReqReady, 1'b1);
        check("rst_busy", Busy, 1'b0);
        check("rst_resp", {RespValid, RespErr, RespWrite, RespData}, 0);
        check("rst_mem", {MemWrite, MemRead, MemAddr, MemWriteData}, 0);
        repeat (2) @(posedge Clock);
        #1 Reset_n = 1'b1;

        preload(8'h02, 16'd7);
        preload(8'h04, 16'd8);
        preload(8'h06, 16'd9);
        preload(8'h10, 16'h00AA);

        // Store 0x000E <- 21 then load it back
        RespReady = 1'b1;
        gb = got_q.size();
        wb = wr_log.size();
        send(1'b1, 16'h000E, 16'd21);
        send(1'b0, 16'h000E, 16'h0000);
        wait_idle();
        check("t27_nwrites", wr_log.size() - wb, 1);
        check("t27_nresp", got_q.size() - gb, 2);
        if (wr_log.size() > wb) check("t27_write", wr_log[wb], {16'd14, 16'd21});
        if (got_q.size() >= gb + 2) begin
            check("t27_resp_store", got_q[gb], {2'b01, 16'd0});
            check("t27_resp_load", got_q[gb + 1], {2'b00, 16'd21});
        end

        // Single-request latency from an idle unit
        send(1'b0, 16'h0004, 16'h0000);
        check("lat_k_read", {MemRead, RespValid}, 2'b00);
        @(posedge Clock); #1;
        check("lat_k1_read", {MemRead, MemAddr}, {1'b1, 16'h0004});
        @(posedge Clock); #1;
        check("lat_k2_resp", {MemRead, RespValid, RespData}, {2'b01, 16'd8});
        wait_idle();

        // Back-to-back stores with RespReady held high: one response every 3 cycles
        cb = resp_cyc_q.size();
        for (int i = 0; i < 4; i++) send(1'b1, 16'h0020 + 16'(2 * i), 16'h0100 + 16'(i));
        wait_idle();
        check("tput_nresp", resp_cyc_q.size() - cb, 4);
        if (resp_cyc_q.size() >= cb + 4) begin
            for (int i = 1; i < 4; i++) check("tput_gap", resp_cyc_q[cb + i] - resp_cyc_q[cb + i - 1], 3);
        end

        // Full queue with RespReady low
        RespReady = 1'b0;
        gb = got_q.size();
        send(1'b0, 16'h0002, 16'h0000);
        send(1'b0, 16'h0004, 16'h0000);
        send(1'b0, 16'h0006, 16'h0000);
        check("full_ready_low", ReqReady, 1'b0);
        ReqValid = 1'b1;
        ReqWrite = 1'b0;
        ReqAddr  = 16'h000E;
        a0 = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check("full_hold_ready", ReqReady, 1'b0);
        end
        @(posedge Clock); #1;
        check("full_not_accepted", acc_cnt - a0, 0);
        RespReady = 1'b1;
        send(1'b0, 16'h000E, 16'h0000);
        wait_idle();
        check("full_nresp", got_q.size() - gb, 4);
        if (got_q.size() >= gb + 4) begin
            check("full_r0", got_q[gb], {2'b00, 16'd7});
            check("full_r1", got_q[gb + 1], {2'b00, 16'd8});
            check("full_r2", got_q[gb + 2], {2'b00, 16'd9});
            check("full_r3", got_q[gb + 3], {2'b00, 16'd21});
        end

        // Loads with RespReady toggling
        RespReady = 1'b0;
        gb = got_q.size();
        pat = 24'b1011_0010_1100_1001_0110_0011;
        fork
            begin
                send(1'b0, 16'h0002, 16'h0000);
                send(1'b0, 16'h0004, 16'h0000);
                send(1'b0, 16'h0006, 16'h0000);
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    @(posedge Clock); #1;
                    RespReady = pat[i];
                end
            end
        join
        RespReady = 1'b1;
        wait_idle();
        check("tog_nresp", got_q.size() - gb, 3);
        if (got_q.size() >= gb + 3) begin
            check("tog_r0", got_q[gb], {2'b00, 16'd7});
            check("tog_r1", got_q[gb + 1], {2'b00, 16'd8});
            check("tog_r2", got_q[gb + 2], {2'b00, 16'd9});
        end

        // Odd addresses
        gb = got_q.size();
        rb = rd_log.size();
        wb = wr_log.size();
        send(1'b0, 16'h0003, 16'h0000);
        send(1'b1, 16'h0005, 16'h0055);
        wait_idle();
        check("odd_nresp", got_q.size() - gb, 2);
`ifdef MAU_ALIGN_CHECK_EN
        check("odd_nreads", rd_log.size() - rb, 0);
        check("odd_nwrites", wr_log.size() - wb, 0);
        if (got_q.size() >= gb + 2) begin
            check("odd_load_resp", got_q[gb], {2'b10, 16'd0});
            check("odd_store_resp", got_q[gb + 1], {2'b11, 16'd0});
        end
`else
        check("odd_nreads", rd_log.size() - rb, 1);
        check("odd_nwrites", wr_log.size() - wb, 1);
        if (rd_log.size() > rb) check("odd_read_addr", rd_log[rb], 16'h0003);
        if (wr_log.size() > wb) check("odd_write", wr_log[wb], {16'h0005, 16'h0055});
        if (got_q.size() >= gb + 2) begin
            check("odd_load_resp", got_q[gb], {2'b00, 16'd0});
            check("odd_store_resp", got_q[gb + 1], {2'b01, 16'd0});
        end
`endif

        // Reset during ISSUE_W of store 0x0010 <- 5
        send(1'b1, 16'h0010, 16'd5);
        @(posedge Clock); #1;
        check("rst_mid_strobe", {MemWrite, MemAddr, MemWriteData}, {1'b1, 16'h0010, 16'd5});
        #1 Reset_n = 1'b0;
        #1;
        check("rst_mid_drop", {MemWrite, MemRead, MemAddr, MemWriteData}, 0);
        check("rst_mid_state", {RespValid, Busy, ReqReady}, 3'b001);
        repeat (2) @(posedge Clock);
        #1 Reset_n = 1'b1;
        gb = got_q.size();
        wb = wr_log.size();
        c0 = cyc;
        check("post_rst_ready", ReqReady, 1'b1);
        send(1'b0, 16'h0010, 16'h0000);
        check("post_rst_first_edge", cyc - c0, 1);
        wait_idle();
        check("post_rst_nresp", got_q.size() - gb, 1);
        check("post_rst_nwrites", wr_log.size() - wb, 0);
        if (got_q.size() > gb) check("post_rst_data", got_q[gb], {2'b00, 16'h00AA});

        check("resp_vs_accept", resp_cnt, acc_cnt - disc_cnt);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH, default 2, request queue entries (power of two, >=2) SHALL be supported.
REQ-002 Clock  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 Reset_n  input  1  reset, asynchronous, active-low.
REQ-004 ReqValid  input  1  request present; ReqReady  output  1  queue can accept.
REQ-005 ReqWrite  input  1  1=store, 0=load; ReqAddr  input  16  byte address; ReqWData  input  16  store data.
REQ-006 RespValid  output  1  response present; RespReady  input  1  consumer accepts response.
REQ-007 RespData  output  16  load data (0 for stores); RespWrite  output  1  response belongs to a store; RespErr  output  1  error flag.
REQ-008 MemAddr  output  16; MemWriteData  output  16; MemWrite  output  1; MemRead  output  1; MemReadData  input  16 (combinational memory read, synchronous write on rising Clock).
REQ-009 Busy  output  1  queue non-empty or FSM not IDLE.

Function
REQ-010 Request SHALL be accepted on a rising edge where ReqValid=1 and ReqReady=1; accepted requests SHALL be queued FIFO, in order.
REQ-011 ReqReady SHALL be !full, derived from registered count only; no push when full even if a pop occurs the same edge.
REQ-012 Push and pop on the same edge SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-013 FSM states: IDLE, ISSUE_W, ISSUE_R, RESP.
REQ-014 IDLE: queue non-empty at edge -> pop head, go ISSUE_W (store) or ISSUE_R (load); else stay.
REQ-015 ISSUE_W: MemWrite=1, MemAddr/MemWriteData = head address/data for exactly one cycle; next edge -> RESP with RespData=0, RespWrite=1.
REQ-016 ISSUE_R: MemRead=1, MemAddr = head address for exactly one cycle; next edge SHALL capture MemReadData into RespData, RespWrite=0, -> RESP.
REQ-017 RESP: RespValid=1 and RespData/RespWrite/RespErr stable until an edge with RespReady=1; that edge -> IDLE.
REQ-018 MemWrite and MemRead SHALL never both be 1; both 0 in IDLE and RESP; MemAddr/MemWriteData 0 when neither asserted.
REQ-019 Latency: request accepted at edge k with FSM IDLE and queue empty -> memory strobe during cycle k+1..k+2, RespValid high after edge k+2.
REQ-020 Back-to-back: with RespReady held 1, throughput SHALL be one request per 3 cycles; queue absorbs DEPTH outstanding requests.
REQ-021 Exactly one response SHALL be produced per accepted request, in acceptance order.

Reset
REQ-022 Reset_n=0 SHALL immediately clear: queue (count 0, pointers 0), FSM=IDLE, RespValid=0, RespData=0, RespWrite=0, RespErr=0, MemWrite=0, MemRead=0, MemAddr=0, MemWriteData=0, Busy=0, ReqReady=1.
REQ-023 Reset mid-operation SHALL discard queued and in-flight requests with no memory write completing after Reset_n falls; no response SHALL be produced for them.
REQ-024 After Reset_n rises, first request SHALL be acceptable at the first rising edge.

Configuration
REQ-025 Macro MAU_ALIGN_CHECK_EN defined: a popped request with ReqAddr[0]=1 SHALL skip ISSUE_W/ISSUE_R (no memory strobe), go IDLE -> RESP directly with RespErr=1, RespData=0, RespWrite per request.
REQ-026 MAU_ALIGN_CHECK_EN undefined: RespErr SHALL be constant 0 and all addresses SHALL be issued unmodified.

Verification
REQ-027 Store 0x000E<-21 then load 0x000E, RespReady=1 -> MemWrite one cycle with MemAddr=14/MemWriteData=21; second response RespData=21, RespWrite=0.
REQ-028 DEPTH=2, RespReady=0, push 3 requests -> ReqReady=0 after third accepted; fourth ReqValid not accepted until RespReady=1 drains one response.
REQ-029 Loads to 2,4,6 preloaded with 7,8,9, RespReady toggling -> responses 7,8,9 in order, each held stable while RespReady=0.
REQ-030 Reset_n low during ISSUE_W of store 0x0010<-5 -> MemWrite drops immediately, load 0x0010 afterward returns prior contents, no stale response.
REQ-031 MAU_ALIGN_CHECK_EN defined, load 0x0003 -> no MemRead pulse, RespErr=1, RespData=0; undefined -> MemRead with MemAddr=3, RespErr=0.
REQ-032 Assertion throughout all scenarios: never MemWrite&&MemRead; response count equals accepted count.
